// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: turns debounced direction buttons into a small queue of
// accepted headings and releases one of them into dir_o on each game tick.
module snake_dir_ctrl #(
    parameter int         QDEPTH   = 2,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    input  logic       tick_i,
    input  logic       game_run_i,
    output logic [1:0] dir_o,
    output logic       dir_valid_o,
    output logic [1:0] q_count_o,
    output logic       drop_o
);

    typedef enum logic {IDLE, RUN} state_e;

    state_e     state_q, state_d;
    logic [3:0] btnHist_q;
    logic [3:0] btnNow;
    logic [3:0] press;
    logic [1:0] dir_q, dir_d;
    logic       dirValid_q, dirValid_d;
    logic       drop_q, drop_d;
    logic [1:0] count_q, count_d;
    logic [1:0] head_q, head_d;
    logic [1:0] tail_q, tail_d;
    logic [1:0] mem_q [4];
    logic [1:0] cand;
    logic [1:0] refDir;
    logic       anyPress, multiPress, candOk, push, pop;

    function automatic logic [1:0] ptrInc(input logic [1:0] p);
        return (p == 2'(QDEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    function automatic logic [1:0] ptrDec(input logic [1:0] p);
        return (p == 2'd0) ? 2'(QDEPTH - 1) : p - 2'd1;
    endfunction

    // Buttons are active-low: a press is last-cycle high, this-cycle low.
    assign btnNow = {btn_up_i, btn_down_i, btn_left_i, btn_right_i};
    assign press  = btnHist_q & ~btnNow;

    always_comb begin
        cand = 2'd3;
        if (press[3])      cand = 2'd0;
        else if (press[2]) cand = 2'd1;
        else if (press[1]) cand = 2'd2;
        anyPress   = |press;
        multiPress = (press & (press - 4'd1)) != 4'd0;
        refDir     = (count_q != 2'd0) ? mem_q[ptrDec(tail_q)] : dir_q;
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        dirValid_d = 1'b0;
        drop_d     = 1'b0;
        count_d    = count_q;
        head_d     = head_q;
        tail_d     = tail_q;
        push       = 1'b0;
        pop        = 1'b0;
        candOk     = 1'b0;
        case (state_q)
            IDLE: begin
                if (game_run_i) begin
                    state_d = RUN;
                    dir_d   = INIT_DIR;
                    count_d = 2'd0;
                    head_d  = 2'd0;
                    tail_d  = 2'd0;
                end
            end
            RUN: begin
                if (!game_run_i) begin
                    state_d = IDLE;
                    count_d = 2'd0;
                    head_d  = 2'd0;
                    tail_d  = 2'd0;
                end else begin
                    pop    = tick_i && (count_q != 2'd0);
                    // A full queue still takes a press when a tick frees a slot.
                    candOk = anyPress && (cand != refDir) && (cand != (refDir ^ 2'b01))
                             && ((count_q < 2'(QDEPTH)) || pop);
                    push       = candOk;
                    dirValid_d = tick_i;
                    drop_d     = multiPress || (anyPress && !candOk);
                    if (pop) begin
                        dir_d  = mem_q[head_q];
                        head_d = ptrInc(head_q);
                    end
                    if (push) tail_d = ptrInc(tail_q);
                    if (push && !pop)      count_d = count_q + 2'd1;
                    else if (pop && !push) count_d = count_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            btnHist_q  <= 4'b1111;
            dir_q      <= INIT_DIR;
            dirValid_q <= 1'b0;
            drop_q     <= 1'b0;
            count_q    <= 2'd0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            btnHist_q  <= btnNow;
            dir_q      <= dir_d;
            dirValid_q <= dirValid_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) mem_q[i] <= 2'd0;
        end else if (push) begin
            mem_q[tail_q] <= cand;
        end
    end

    assign dir_o       = dir_q;
    assign dir_valid_o = dirValid_q;
    assign q_count_o   = count_q;
    assign drop_o      = drop_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Randomised scoreboard bench for snake_dir_ctrl, checked against a
// queue-based model of the heading scheduler.
module tb_snake_dir_ctrl;

    localparam int         QDEPTH   = 2;
    localparam logic [1:0] INIT_DIR = 2'd3;

    logic       clk_i = 1'b0;
    logic       reset_n;
    logic       btn_up_i, btn_down_i, btn_left_i, btn_right_i;
    logic       tick_i, game_run_i;
    logic [1:0] dir_o;
    logic       dir_valid_o;
    logic [1:0] q_count_o;
    logic       drop_o;

    typedef struct packed {
        logic [1:0] dir;
        logic       valid;
        logic [1:0] count;
        logic       drop;
    } expect_t;

    expect_t sb[$];
    int      vectors = 0;
    int      miscompares = 0;

    bit       mRunning;
    int       mDir;
    int       mQ[$];
    bit [3:0] mPrevHeld;
    bit       mValid, mDrop;

    snake_dir_ctrl #(.QDEPTH(QDEPTH), .INIT_DIR(INIT_DIR)) dut (
        .clk_i      (clk_i),
        .reset_n    (reset_n),
        .btn_up_i   (btn_up_i),
        .btn_down_i (btn_down_i),
        .btn_left_i (btn_left_i),
        .btn_right_i(btn_right_i),
        .tick_i     (tick_i),
        .game_run_i (game_run_i),
        .dir_o      (dir_o),
        .dir_valid_o(dir_valid_o),
        .q_count_o  (q_count_o),
        .drop_o     (drop_o)
    );

    always #5 clk_i = ~clk_i;

    // held[d] = 1 means the button for direction code d is pushed.
    task automatic modelStep(input bit rstN, input bit [3:0] held, input bit tick, input bit run);
        bit [3:0] pressed;
        int       first;
        int       refD;
        bit       ok;
        bit       pop;
        if (!rstN) begin
            mRunning  = 0;
            mDir      = INIT_DIR;
            mQ.delete();
            mPrevHeld = '0;
            mValid    = 0;
            mDrop     = 0;
            return;
        end
        pressed   = held & ~mPrevHeld;
        mPrevHeld = held;
        mValid    = 0;
        mDrop     = 0;
        if (!mRunning) begin
            if (run) begin
                mRunning = 1;
                mDir     = INIT_DIR;
                mQ.delete();
            end
        end else if (!run) begin
            mRunning = 0;
            mQ.delete();
        end else begin
            first = -1;
            for (int i = 3; i >= 0; i--) if (pressed[i]) first = i;
            pop = tick && (mQ.size() > 0);
            ok  = 0;
            if (first >= 0) begin
                refD = (mQ.size() > 0) ? mQ[$] : mDir;
                ok   = (first != refD) && (first != (refD ^ 1)) && ((mQ.size() < QDEPTH) || pop);
            end
            mDrop = ($countones(pressed) > 1) || ((first >= 0) && !ok);
            if (pop) mDir = mQ.pop_front();
            if (ok) mQ.push_back(first);
            mValid = tick;
        end
    endtask

    task automatic checkOutput(input string name, input expect_t e);
        vectors += 4;
        if (dir_o !== e.dir) begin
            miscompares++;
            $display("[TB] FAIL %s.dir got %0d expected %0d at %0t", name, dir_o, e.dir, $time);
        end
        if (dir_valid_o !== e.valid) begin
            miscompares++;
            $display("[TB] FAIL %s.dir_valid got %0b expected %0b at %0t", name, dir_valid_o, e.valid, $time);
        end
        if (q_count_o !== e.count) begin
            miscompares++;
            $display("[TB] FAIL %s.q_count got %0d expected %0d at %0t", name, q_count_o, e.count, $time);
        end
        if (drop_o !== e.drop) begin
            miscompares++;
            $display("[TB] FAIL %s.drop got %0b expected %0b at %0t", name, drop_o, e.drop, $time);
        end
    endtask

    task automatic applyStimulus(input bit rstN, input bit [3:0] held, input bit tick, input bit run);
        expect_t e;
        expect_t r;
        @(negedge clk_i);
        reset_n     = rstN;
        btn_up_i    = ~held[0];
        btn_down_i  = ~held[1];
        btn_left_i  = ~held[2];
        btn_right_i = ~held[3];
        tick_i      = tick;
        game_run_i  = run;
        modelStep(rstN, held, tick, run);
        e.dir   = 2'(mDir);
        e.valid = mValid;
        e.count = 2'(mQ.size());
        e.drop  = mDrop;
        sb.push_back(e);
        if (!rstN) begin
            #1;
            r.dir   = INIT_DIR;
            r.valid = 1'b0;
            r.count = 2'd0;
            r.drop  = 1'b0;
            checkOutput("async_reset", r);
        end
    endtask

    // Monitor: the DUT presents a fresh output set after every clock edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk_i);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput("cycle", e);
            end
        end
    end

    initial begin
        bit [3:0] held;
        bit       run;
        bit       rstN;
        reset_n     = 1'b0;
        btn_up_i    = 1'b1;
        btn_down_i  = 1'b1;
        btn_left_i  = 1'b1;
        btn_right_i = 1'b1;
        tick_i      = 1'b0;
        game_run_i  = 1'b0;

        applyStimulus(0, 4'b0000, 0, 0);
        applyStimulus(0, 4'b0000, 0, 0);
        // Start the game and tick once on the initial heading.
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        // Up accepted then released on a tick.
        applyStimulus(1, 4'b0001, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        // Back to right, then opposite and repeat presses.
        applyStimulus(1, 4'b1000, 0, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0100, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b1000, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        // Up, left, down before one tick: queue fills, down dropped.
        applyStimulus(1, 4'b0001, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0100, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0010, 0, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        // Full queue plus push and pop in the same cycle.
        applyStimulus(1, 4'b0001, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b1000, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0001, 1, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        // Same-cycle up + left while heading right.
        applyStimulus(1, 4'b1000, 1, 1);
        applyStimulus(1, 4'b0000, 1, 1);
        applyStimulus(1, 4'b0101, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        // Two queued, stop and restart with down held across the restart.
        applyStimulus(1, 4'b0100, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b0001, 0, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        applyStimulus(1, 4'b1000, 0, 1);
        applyStimulus(1, 4'b0010, 0, 0);
        applyStimulus(1, 4'b0010, 0, 0);
        applyStimulus(1, 4'b0010, 0, 1);
        applyStimulus(1, 4'b0010, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1);
        // Mid-game reset with right held through the reset.
        applyStimulus(1, 4'b0001, 0, 1);
        applyStimulus(0, 4'b1000, 0, 1);
        applyStimulus(1, 4'b1000, 0, 1);
        applyStimulus(1, 4'b1000, 1, 1);
        applyStimulus(1, 4'b0000, 0, 1);

        held = '0;
        run  = 1;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 3) == 0) held[b] = ~held[b];
            if (run && $urandom_range(0, 99) == 0) run = 0;
            else if (!run && $urandom_range(0, 4) == 0) run = 1;
            rstN = ($urandom_range(0, 399) != 0);
            applyStimulus(rstN, held, ($urandom_range(0, 4) == 0), run);
        end

        applyStimulus(1, 4'b0000, 0, 1);
        @(posedge clk_i);
        #3;
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain pending %0d expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/snake_dir_ctrl.md
Name: snake_dir_ctrl

Overview:
Direction scheduler between the four debounced direction buttons and the snake movement engine. It converts button presses into direction requests and arbitrates presses that land in the same cycle. Requests that would reverse or repeat the heading are rejected. Accepted requests wait in a small queue, and one is released per game tick, so two quick presses between ticks are not lost.

Parameters:
QDEPTH, 2, number of pending direction entries the queue holds (legal range 1..3).
INIT_DIR, 2'd3, heading loaded at reset and at game start. Encoding: 0 = up, 1 = down, 2 = left, 3 = right.

Ports:
clk_i  input  1  system clock.
reset_n  input  1  asynchronous, active-low reset.
btn_up_i  input  1  debounced up button; active-low, idle high.
btn_down_i  input  1  debounced down button; active-low, idle high.
btn_left_i  input  1  debounced left button; active-low, idle high.
btn_right_i  input  1  debounced right button; active-low, idle high.
tick_i  input  1  one-cycle game-step strobe.
game_run_i  input  1  level signal; 1 = game running.
dir_o  output  2  current heading.
dir_valid_o  output  1  one-cycle pulse, one cycle after each tick in RUN.
q_count_o  output  2  number of queued entries.
drop_o  output  1  one-cycle pulse when any press in a cycle is rejected.

Behaviour:
- Interface: one clock, clk_i. Reset is asynchronous and active-low (reset_n).
- Reset values:
  - dir_o = INIT_DIR; dir_valid_o = 0; q_count_o = 0; drop_o = 0.
  - State = IDLE; button history registers = 4'b1111; queue pointers = 0.
- Press detection:
  - A press is a registered high->low transition: prev = 1 and now = 0.
  - History registers update every cycle in both states.
  - A button held low through reset or through game start produces no press.
- FSM states: IDLE and RUN.
  - IDLE -> RUN when game_run_i = 1. On that entry cycle, dir_o reloads INIT_DIR and the queue clears.
  - RUN -> IDLE when game_run_i = 0. The queue is flushed and dir_o holds its value.
  - In IDLE, presses are ignored (no drop_o) and ticks are ignored (no dir_valid_o).
- Same-cycle arbitration: priority is up > down > left > right. Only the highest-priority press is a candidate. Every other press that cycle is rejected and asserts drop_o.
- Candidate validity:
  - Reference heading = the queue tail entry if the queue is non-empty, otherwise dir_o.
  - Reject if candidate == reference.
  - Reject if candidate == reference ^ 2'b01 (the opposite direction).
  - Reject if the queue is full and no pop happens in the same cycle.
  - On rejection, drop_o pulses in the next cycle.
- Push latency: a press sampled in cycle N makes q_count_o increment in cycle N+1.
- Tick in RUN, sampled in cycle T:
  - If the queue is non-empty, the head is popped into dir_o, visible in cycle T+1.
  - dir_valid_o = 1 in cycle T+1 whether or not a pop occurred. With an empty queue, dir_o is unchanged.
- Push and pop in the same cycle:
  - Validity is checked against the tail as it was before the pop.
  - A push into a full queue is accepted when a pop happens that cycle; count stays at QDEPTH.
  - With one entry, push+pop leaves count = 1, holding the new entry.
- Queue storage:
  - Circular buffer with head and tail pointers that wrap modulo QDEPTH.
  - q_count_o never exceeds QDEPTH and never underflows.
- Reset asserted mid-game: all state returns to reset values immediately, with no dependence on the clock.

Test Plan:
1. Reset release, game_run_i = 1, one tick -> dir_o = 3, dir_valid_o pulses once, q_count_o = 0.
2. Heading right, press up, then tick -> q_count_o = 1 one cycle after the press. After the tick, dir_o = 0 and q_count_o = 0.
3. Heading right, press left -> drop_o pulses, q_count_o stays 0. Then press right -> drop_o pulses again.
4. Heading right, press up, then left, then down, all before one tick (QDEPTH = 2):
   - up and left are accepted; down is dropped because the queue is full.
   - Tick 1 -> dir_o = 0 (up). Tick 2 -> dir_o = 2 (left).
5. Up and left pressed in the same cycle while heading right -> up is queued, left is dropped, drop_o pulses once.
6. Queue holds 2 entries, game_run_i falls, then rises -> q_count_o = 0 and dir_o = 3. A button held low across the restart produces no entry. reset_n pulsed low mid-game -> all outputs return to reset values asynchronously.
